// File: rtl/irq_collector_if.sv
// rtl/irq_collector_if.sv - config write and interrupt presentation handshake between CPU master and irq_collector
interface irq_collector_if #(
    parameter int N_IRQ = 4,
    parameter int IDW   = 2
);
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [N_IRQ-1:0] cfg_wdata;
    logic             irq_valid;
    logic [IDW-1:0]   irq_id;
    logic             irq_ack;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, irq_ack,
        input  irq_valid, irq_id
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, irq_ack,
        output irq_valid, irq_id
    );
endinterface

// File: rtl/irq_collector.sv
// rtl/irq_collector.sv - level/edge interrupt collector with priority presentation and lost-event counter
module irq_collector #(
    parameter int N_IRQ = 4,
    parameter int IDW   = 2,
    parameter int OVF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq_in,
    irq_collector_if.slave    bus,
    output logic [N_IRQ-1:0]  pending_out,
    output logic [N_IRQ-1:0]  mask_out,
    output logic [OVF_W-1:0]  ovf_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_W1C  = 2'd2;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic [N_IRQ-1:0]   edge_q, edge_d;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [N_IRQ-1:0]   irq_in_q, irq_in_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;

    logic [N_IRQ-1:0]   set_vec;
    logic [N_IRQ-1:0]   ack_clr;
    logic [N_IRQ-1:0]   w1c_clr;
    logic [N_IRQ-1:0]   clr_vec;
    logic [N_IRQ-1:0]   presentable;
    logic [IDW-1:0]     first_id;
    logic               found;
    logic               ack_fire;
    logic               lost;

    always_comb begin
        irq_in_d = irq_in;
        // Edge mode compares against last cycle's sample; level mode re-asserts every cycle.
        set_vec  = (edge_q & irq_in & ~irq_in_q) | (~edge_q & irq_in);

        ack_fire = (state_q == S_REQ) && bus.irq_ack;
        ack_clr  = '0;
        if (ack_fire) begin
            ack_clr[id_q] = 1'b1;
        end
        w1c_clr = (bus.cfg_we && (bus.cfg_addr == ADDR_W1C)) ? bus.cfg_wdata : '0;
        clr_vec = ack_clr | w1c_clr;

        // OR-ing set after the clear lets a fresh event win over a same-cycle clear.
        pending_d = (pending_q & ~clr_vec) | set_vec;

        lost  = |(set_vec & pending_q & ~clr_vec);
        ovf_d = ovf_q;
        if (lost && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end

        mask_d = mask_q;
        edge_d = edge_q;
        if (bus.cfg_we && (bus.cfg_addr == ADDR_MASK)) begin
            mask_d = bus.cfg_wdata;
        end
        if (bus.cfg_we && (bus.cfg_addr == ADDR_EDGE)) begin
            edge_d = bus.cfg_wdata;
        end

        presentable = pending_q & mask_q;
        first_id    = '0;
        found       = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (presentable[i] && !found) begin
                first_id = IDW'(i);
                found    = 1'b1;
            end
        end

        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_REQ;
                    valid_d = 1'b1;
                    id_d    = first_id;
                end
            end
            S_REQ: begin
                // id stays frozen here even if its pending bit or mask goes away.
                if (bus.irq_ack) begin
                    state_d = S_CLEAR;
                    valid_d = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            irq_in_q  <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            pending_q <= pending_d;
            irq_in_q  <= irq_in_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_id    = id_q;
    assign pending_out   = pending_q;
    assign mask_out      = mask_q;
    assign ovf_count     = ovf_q;

endmodule

// File: tb/tb_irq_collector.sv
// tb/tb_irq_collector.sv - self-checking bench for irq_collector: vector table, directed corners, random vs model
module tb_irq_collector;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int OW  = 8;

    logic          clk    = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst    = 1'b1;
    logic [N-1:0]  irq_in = '0;
    logic [N-1:0]  pending_out;
    logic [N-1:0]  mask_out;
    logic [OW-1:0] ovf_count;

    irq_collector_if #(.N_IRQ(N), .IDW(IDW)) bus ();

    irq_collector #(.N_IRQ(N), .IDW(IDW), .OVF_W(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .bus         (bus),
        .pending_out (pending_out),
        .mask_out    (mask_out),
        .ovf_count   (ovf_count)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] in, input logic we, input logic [1:0] addr,
                         input logic [3:0] wd, input logic ack);
        irq_in        = in;
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wd;
        bus.irq_ack   = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: pending set as a bit array, presentation as hold flag + id + cooldown.
    logic [3:0] m_mask, m_edge, m_pend, m_prev;
    int         m_ovf, m_id, m_gap;
    bit         m_hold;

    task automatic model_reset();
        m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0;
        m_ovf = 0; m_id = 0; m_gap = 0; m_hold = 0;
    endtask

    task automatic model_step(input logic [3:0] in, input logic we, input logic [1:0] addr,
                              input logic [3:0] wd, input logic ack);
        logic [3:0] s, clr, avail;
        for (int i = 0; i < 4; i++) s[i] = m_edge[i] ? (in[i] & ~m_prev[i]) : in[i];
        clr = '0;
        if (m_hold && ack) clr[m_id] = 1'b1;
        if (we && addr == 2'd2) clr = clr | wd;
        avail = m_pend & m_mask;
        if ((s & m_pend & ~clr) != 4'h0 && m_ovf < 255) m_ovf++;
        m_pend = (m_pend & ~clr) | s;
        if (m_hold) begin
            if (ack) begin m_hold = 0; m_gap = 1; end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (avail != 4'h0) begin
            m_hold = 1;
            for (int i = 3; i >= 0; i--) if (avail[i]) m_id = i;
        end
        if (we && addr == 2'd0) m_mask = wd;
        if (we && addr == 2'd1) m_edge = wd;
        m_prev = in;
    endtask

    task automatic do_reset();
        drive(4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] irq;
        logic       we;
        logic [1:0] addr;
        logic [3:0] wd;
        logic       ack;
        logic       ev;
        logic [1:0] eid;
        logic [3:0] ep;
        logic [3:0] em;
    } vec_t;

    vec_t tbl[24];

    initial begin
        // T1: reset with the clock stopped
        drive(4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
        #3;
        check("t1_valid", 32'(bus.irq_valid), 32'h0);
        check("t1_id", 32'(bus.irq_id), 32'h0);
        check("t1_pending", 32'(pending_out), 32'h0);
        check("t1_mask", 32'(mask_out), 32'h0);
        check("t1_ovf", 32'(ovf_count), 32'h0);
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // T2/T3 plus W1C-in-REQ, mask-in-REQ, reserved write and edge_mode rewrite
        tbl[0]  = '{4'h0, 1'b1, 2'd0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[1]  = '{4'h0, 1'b1, 2'd1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[2]  = '{4'h2, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h2, 4'hF};
        tbl[3]  = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 2'd1, 4'h2, 4'hF};
        tbl[4]  = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[5]  = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[6]  = '{4'hC, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'hC, 4'hF};
        tbl[7]  = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 2'd2, 4'hC, 4'hF};
        tbl[8]  = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h8, 4'hF};
        tbl[9]  = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h8, 4'hF};
        tbl[10] = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h8, 4'hF};
        tbl[11] = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[12] = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[13] = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[14] = '{4'h1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h1, 4'hF};
        tbl[15] = '{4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h1, 4'h0};
        tbl[16] = '{4'h0, 1'b1, 2'd2, 4'h1, 1'b0, 1'b1, 2'd0, 4'h0, 4'h0};
        tbl[17] = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[18] = '{4'h0, 1'b1, 2'd0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[19] = '{4'h0, 1'b1, 2'd3, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[20] = '{4'h8, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h8, 4'hF};
        tbl[21] = '{4'h0, 1'b1, 2'd1, 4'h0, 1'b0, 1'b1, 2'd3, 4'h8, 4'hF};
        tbl[22] = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF};
        tbl[23] = '{4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hF};
        for (int r = 0; r < 24; r++) begin
            drive(tbl[r].irq, tbl[r].we, tbl[r].addr, tbl[r].wd, tbl[r].ack);
            tick();
            check($sformatf("tbl%0d_valid", r), 32'(bus.irq_valid), 32'(tbl[r].ev));
            if (tbl[r].ev) check($sformatf("tbl%0d_id", r), 32'(bus.irq_id), 32'(tbl[r].eid));
            check($sformatf("tbl%0d_pending", r), 32'(pending_out), 32'(tbl[r].ep));
            check($sformatf("tbl%0d_mask", r), 32'(mask_out), 32'(tbl[r].em));
        end

        // T4: level source held through its ack
        do_reset();
        drive(4'h0, 1'b1, 2'd0, 4'hF, 1'b0); tick();
        drive(4'h1, 1'b0, 2'd0, 4'h0, 1'b0); tick();
        check("t4_pend_set", 32'(pending_out), 32'h1);
        tick();
        check("t4_valid1", 32'(bus.irq_valid), 32'h1);
        check("t4_id1", 32'(bus.irq_id), 32'h0);
        drive(4'h1, 1'b0, 2'd0, 4'h0, 1'b1); tick();
        check("t4_ack_valid", 32'(bus.irq_valid), 32'h0);
        check("t4_repend", 32'(pending_out), 32'h1);
        drive(4'h1, 1'b0, 2'd0, 4'h0, 1'b0); tick();
        check("t4_gap_valid", 32'(bus.irq_valid), 32'h0);
        tick();
        check("t4_represent", 32'(bus.irq_valid), 32'h1);
        check("t4_id2", 32'(bus.irq_id), 32'h0);
        drive(4'h0, 1'b0, 2'd0, 4'h0, 1'b1); tick();
        check("t4_drop_pend", 32'(pending_out), 32'h0);
        drive(4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t4_quiet%0d", k), 32'(bus.irq_valid), 32'h0);
        end

        // T5: lost-event counting and saturation
        do_reset();
        drive(4'h0, 1'b1, 2'd1, 4'h4, 1'b0); tick();
        for (int p = 1; p <= 258; p++) begin
            drive(4'h4, 1'b0, 2'd0, 4'h0, 1'b0); tick();
            drive(4'h0, 1'b0, 2'd0, 4'h0, 1'b0); tick();
            if (p == 3) begin
                check("t5_pend3", 32'(pending_out), 32'h4);
                check("t5_ovf3", 32'(ovf_count), 32'd2);
                check("t5_masked_valid", 32'(bus.irq_valid), 32'h0);
            end
        end
        check("t5_ovf_sat", 32'(ovf_count), 32'd255);
        check("t5_pend_end", 32'(pending_out), 32'h4);

        // T6: async reset while presenting
        do_reset();
        drive(4'h0, 1'b1, 2'd0, 4'hF, 1'b0); tick();
        drive(4'h0, 1'b1, 2'd1, 4'hF, 1'b0); tick();
        drive(4'h2, 1'b0, 2'd0, 4'h0, 1'b0); tick();
        drive(4'h0, 1'b0, 2'd0, 4'h0, 1'b0); tick();
        check("t6_pre_valid", 32'(bus.irq_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(bus.irq_valid), 32'h0);
        check("t6_async_pend", 32'(pending_out), 32'h0);
        check("t6_async_mask", 32'(mask_out), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_quiet%0d", k), 32'(bus.irq_valid), 32'h0);
        end
        drive(4'h0, 1'b1, 2'd0, 4'hF, 1'b0); tick();
        drive(4'h8, 1'b0, 2'd0, 4'h0, 1'b0); tick();
        tick();
        check("t6_new_valid", 32'(bus.irq_valid), 32'h1);
        check("t6_new_id", 32'(bus.irq_id), 32'h3);

        // Randomized run against the reference model
        do_reset();
        begin
            logic [3:0] rin;
            logic       rwe, rack;
            logic [1:0] raddr;
            logic [3:0] rwd;
            logic [31:0] exp_v, act_v;
            rin = '0;
            for (int c = 0; c < 4000; c++) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 9) < 3) rin[b] = ~rin[b];
                rwe   = ($urandom_range(0, 9) == 0);
                raddr = 2'($urandom_range(0, 3));
                rwd   = 4'($urandom_range(0, 15));
                rack  = m_hold ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
                drive(rin, rwe, raddr, rwd, rack);
                model_step(rin, rwe, raddr, rwd, rack);
                tick();
                exp_v = {13'h0, m_hold, (m_hold ? 2'(m_id) : 2'b00), m_pend, m_mask, 8'(m_ovf)};
                act_v = {13'h0, bus.irq_valid, (m_hold ? bus.irq_id : 2'b00), pending_out, mask_out, ovf_count};
                check($sformatf("rand_c%0d", c), act_v, exp_v);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
